// File: rtl/ysyx_23060184_lsu_axi_pkg.sv
// Shared widths, size/response encodings and FSM state type for the LSU AXI4-Lite master.
package ysyx_23060184_lsu_axi_pkg;
    localparam int DATA_WIDTH   = 32;
    localparam int WMASK_LENGTH = 4;
    localparam int ACERR_WIDTH  = 2;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [ACERR_WIDTH-1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B,
        ST_RESP
    } lsu_state_e;
endpackage

// File: rtl/ysyx_23060184_lsu_lane.sv
// Byte-lane steering: store strobe/data replication, load extract and extend, misalign detect.
module ysyx_23060184_lsu_lane
    import ysyx_23060184_lsu_axi_pkg::*;
(
    input  logic [1:0]              size,
    input  logic                    sign_ext,
    input  logic [1:0]              off,
    input  logic [DATA_WIDTH-1:0]   st_data,
    input  logic [DATA_WIDTH-1:0]   ld_raw,
    output logic [WMASK_LENGTH-1:0] wstrb,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   ld_data,
    output logic                    misalign
);
    logic [DATA_WIDTH-1:0] shifted;

    always_comb begin
        shifted  = ld_raw >> {off, 3'b000};
        wstrb    = 4'hF;
        wdata    = st_data;
        ld_data  = ld_raw;
        misalign = 1'b0;
        case (size)
            SZ_B: begin
                wstrb   = 4'b0001 << off;
                wdata   = {4{st_data[7:0]}};
                ld_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wstrb    = 4'b0011 << off;
                wdata    = {2{st_data[15:0]}};
                ld_data  = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
                misalign = off[0];
            end
            SZ_W:    misalign = |off;
            default: misalign = 1'b1;  // size 11 is illegal
        endcase
    end
endmodule

// File: rtl/ysyx_23060184_lsu_axi.sv
// LSU AXI4-Lite master: one outstanding load (AR/R) or store (AW+W/B), result held in RESP.
//  state   | meaning
//  IDLE    | accepting a request from EXU
//  AR      | read address presented
//  R       | waiting for read data
//  AWW     | write address and data presented, each retires on its own handshake
//  B       | waiting for write response
//  RESP    | result held for WBU until resp_ready
module ysyx_23060184_lsu_axi
    import ysyx_23060184_lsu_axi_pkg::*;
(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [1:0]              req_size,
    input  logic                    req_signed,
    input  logic [DATA_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [DATA_WIDTH-1:0]   araddr,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [ACERR_WIDTH-1:0]  rresp,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [DATA_WIDTH-1:0]   awaddr,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [WMASK_LENGTH-1:0] wstrb,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [ACERR_WIDTH-1:0]  bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    lsu_state_e            state, state_nxt;
    logic                  wen_q, signed_q, aw_done, w_done;
    logic [1:0]            size_q;
    logic [DATA_WIDTH-1:0] addr_q, wdata_q, ld_data;
    logic                  misalign, is_idle, aw_fin, w_fin;

    assign is_idle = (state == ST_IDLE);
    assign aw_fin  = aw_done | (awvalid & awready);
    assign w_fin   = w_done | (wvalid & wready);
    assign araddr  = addr_q;
    assign awaddr  = addr_q;

    // In IDLE the lane checks the incoming request; afterwards it works on the captured one.
    ysyx_23060184_lsu_lane u_lane (
        .size     (is_idle ? req_size : size_q),
        .sign_ext (signed_q),
        .off      (is_idle ? req_addr[1:0] : addr_q[1:0]),
        .st_data  (wdata_q),
        .ld_raw   (rdata),
        .wstrb    (wstrb),
        .wdata    (wdata),
        .ld_data  (ld_data),
        .misalign (misalign)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        resp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = misalign ? ST_RESP : (req_wen ? ST_AWW : ST_AR);
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_nxt = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) state_nxt = ST_RESP;
            end
            ST_AWW: begin
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if (aw_fin && w_fin) state_nxt = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) state_nxt = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wen_q      <= 1'b0;
            signed_q   <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    wen_q    <= req_wen;
                    signed_q <= req_signed;
                    size_q   <= req_size;
                    addr_q   <= req_addr;
                    wdata_q  <= req_wdata;
                    aw_done  <= 1'b0;
                    w_done   <= 1'b0;
                    if (misalign) begin
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end
                end
                ST_R: if (rvalid) begin
                    resp_err   <= (rresp != RESP_OKAY);
                    resp_rdata <= (rresp != RESP_OKAY) ? '0 : ld_data;
                end
                ST_AWW: begin
                    if (awvalid && awready) aw_done <= 1'b1;
                    if (wvalid && wready)   w_done  <= 1'b1;
                end
                ST_B: if (bvalid) begin
                    resp_err   <= (bresp != RESP_OKAY);
                    resp_rdata <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule
